// File: rtl/frame_capture_checker.sv
// Video-stream sink: counts pixels/lines/frames, checks H_DISP x V_DISP geometry and builds a
// per-frame rotate-XOR checksum. Define FRAME_CAPTURE_DUMP_EN for a simulation-only pixel dump.
module frame_capture_checker #(
  parameter int H_DISP   = 500,
  parameter int V_DISP   = 500,
  parameter int DATA_W   = 24,
  parameter int N_FRAMES = 1,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              VGA_hsync,
  input  logic              VGA_vsync,
  input  logic              VGA_de,
  input  logic [DATA_W-1:0] VGA_data,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic [31:0]       checksum,
  output logic [2:0]        err_flags,
  output logic              err_sticky,
  output logic              all_done
);

  localparam logic [15:0] H_W = 16'(H_DISP);
  localparam logic [15:0] V_W = 16'(V_DISP);
  localparam logic [15:0] N_W = 16'(N_FRAMES);

  typedef enum logic [2:0] {S_WAIT, S_FRAME, S_END, S_TAIL, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        vs_act, vs_prev, de_prev, vs_start, de_fall;
  logic [15:0] pix, pix_nxt, line_cnt, line_nxt;
  logic [31:0] chk, chk_nxt, latch_chk, data_ext;
  logic [1:0]  err_work, err_nxt, latch_err;
  logic        by_vs, by_vs_nxt, latch, tail_err, restart;
  logic        unused_hsync;

  assign unused_hsync = VGA_hsync;
  assign data_ext     = 32'(VGA_data);
  assign vs_act       = (VGA_vsync == SYNC_POL);
  assign vs_start     = vs_act && !vs_prev;
  assign de_fall      = !VGA_de && de_prev;
  assign frame_done   = (state == S_END);
  assign all_done     = (state == S_DONE);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A frame ended by vsync keeps accumulating during S_END, which is the new frame's first cycle.
  always_comb begin
    state_nxt = state;
    pix_nxt   = pix;
    line_nxt  = line_cnt;
    chk_nxt   = chk;
    err_nxt   = err_work;
    by_vs_nxt = by_vs;
    latch     = 1'b0;
    latch_chk = chk;
    latch_err = err_work;
    tail_err  = 1'b0;
    restart   = 1'b0;
    if (state == S_FRAME || (state == S_END && by_vs)) begin
      if (VGA_de && !vs_start) begin
        pix_nxt = sat_inc(pix);
        chk_nxt = {chk[30:0], chk[31]} ^ data_ext;
      end
      if (de_fall) begin
        if (pix != H_W) err_nxt[0] = 1'b1;
        line_nxt = sat_inc(line_cnt);
        pix_nxt  = '0;
      end
    end
    case (state)
      S_WAIT: begin
        if (vs_start) begin
          restart   = 1'b1;
          state_nxt = S_FRAME;
        end
      end
      S_FRAME: begin
        if ((de_fall && line_nxt == V_W) || vs_start) begin
          if (vs_start && line_nxt < V_W) err_nxt[1] = 1'b1;
          latch     = 1'b1;
          latch_chk = chk_nxt;
          latch_err = err_nxt;
          by_vs_nxt = vs_start;
          restart   = vs_start;
          state_nxt = S_END;
        end
      end
      S_END: begin
        if (frame_cnt == N_W) state_nxt = S_DONE;
        else if (by_vs) state_nxt = S_FRAME;
        else if (vs_start) begin
          restart   = 1'b1;
          state_nxt = S_FRAME;
        end else state_nxt = S_TAIL;
      end
      S_TAIL: begin
        if (vs_start) begin
          restart   = 1'b1;
          state_nxt = S_FRAME;
        end else if (VGA_de) tail_err = 1'b1;
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_WAIT;
    endcase
    // A pixel present in the vsync cycle is the first pixel of the new frame.
    if (restart) begin
      pix_nxt  = VGA_de ? 16'd1 : 16'd0;
      line_nxt = '0;
      chk_nxt  = VGA_de ? data_ext : 32'd0;
      err_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT;
      vs_prev    <= 1'b0;
      de_prev    <= 1'b0;
      pix        <= '0;
      line_cnt   <= '0;
      chk        <= '0;
      err_work   <= '0;
      by_vs      <= 1'b0;
      frame_cnt  <= '0;
      checksum   <= '0;
      err_flags  <= '0;
      err_sticky <= 1'b0;
    end else begin
      state    <= state_nxt;
      vs_prev  <= vs_act;
      de_prev  <= VGA_de;
      pix      <= pix_nxt;
      line_cnt <= line_nxt;
      chk      <= chk_nxt;
      err_work <= err_nxt;
      by_vs    <= by_vs_nxt;
      if (latch) begin
        checksum   <= latch_chk;
        err_flags  <= {1'b0, latch_err};
        frame_cnt  <= sat_inc(frame_cnt);
        err_sticky <= err_sticky | (|latch_err);
      end else if (tail_err) begin
        err_flags[2] <= 1'b1;
        err_sticky   <= 1'b1;
      end
    end
  end

`ifdef FRAME_CAPTURE_DUMP_EN
  always @(posedge clk) begin
    if (rst_n && state == S_FRAME && VGA_de) $display("%h", VGA_data);
    if (rst_n && state != S_DONE && state_nxt == S_DONE) begin
      $stop;
    end
  end
`endif

endmodule

// File: tb/tb_frame_capture_checker.sv
// Directed bench for frame_capture_checker with an 8x4 geometry and two frames to completion.
module tb_frame_capture_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        de = 1'b0;
  logic [23:0] data = '0;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic [31:0] checksum;
  logic [2:0]  err_flags;
  logic        err_sticky;
  logic        all_done;

  int tests = 0;
  int fails = 0;
  int done_pulses = 0;
  int base;

  frame_capture_checker #(
    .H_DISP(8), .V_DISP(4), .DATA_W(24), .N_FRAMES(2), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .VGA_hsync(hsync), .VGA_vsync(vsync), .VGA_de(de),
    .VGA_data(data), .frame_done(frame_done), .frame_cnt(frame_cnt), .checksum(checksum),
    .err_flags(err_flags), .err_sticky(err_sticky), .all_done(all_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_pulses++;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive(input logic vs_in, input logic de_in, input logic [23:0] d);
    vsync = vs_in;
    de    = de_in;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int n, input logic [23:0] d);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, d);
    drive(1'b1, 1'b0, 24'h0);
  endtask

  task automatic vsync_pulse();
    drive(1'b0, 1'b0, 24'h0);
    drive(1'b0, 1'b0, 24'h0);
    drive(1'b1, 1'b0, 24'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vsync = 1'b1;
    de    = 1'b0;
    data  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 24'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("[TB] FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
    tests++; if (checksum !== 32'd0) begin fails++; $display("[TB] FAIL rst_checksum: got %h want 0", checksum); end
    tests++; if (err_flags !== 3'b000) begin fails++; $display("[TB] FAIL rst_err_flags: got %b want 000", err_flags); end
    tests++; if (err_sticky !== 1'b0) begin fails++; $display("[TB] FAIL rst_err_sticky: got %b want 0", err_sticky); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL rst_frame_done: got %b want 0", frame_done); end
    tests++; if (all_done !== 1'b0) begin fails++; $display("[TB] FAIL rst_all_done: got %b want 0", all_done); end
  endtask

  task automatic test_clean_frames();
    do_reset();
    send_line(5, 24'h123456); drive(1'b1, 1'b0, 24'h0);
    send_line(8, 24'hABCDEF); drive(1'b1, 1'b0, 24'h0);
    base = done_pulses;
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin send_line(8, 24'h1); drive(1'b1, 1'b0, 24'h0); end
    send_line(8, 24'h1);
    tests++; if (frame_done !== 1'b1) begin fails++; $display("[TB] FAIL clean_f1_done: got %b want 1", frame_done); end
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("[TB] FAIL clean_f1_cnt: got %0d want 1", frame_cnt); end
    tests++; if (checksum !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL clean_f1_chk: got %h want ffffffff", checksum); end
    tests++; if (err_flags !== 3'b000) begin fails++; $display("[TB] FAIL clean_f1_err: got %b want 000", err_flags); end
    drive(1'b1, 1'b0, 24'h0);
    tests++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL clean_pulse_width: got %b want 0", frame_done); end
    tests++; if (all_done !== 1'b0) begin fails++; $display("[TB] FAIL clean_f1_all_done: got %b want 0", all_done); end
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin send_line(8, 24'h1); drive(1'b1, 1'b0, 24'h0); end
    send_line(8, 24'h1);
    tests++; if (frame_cnt !== 16'd2) begin fails++; $display("[TB] FAIL clean_f2_cnt: got %0d want 2", frame_cnt); end
    drive(1'b1, 1'b0, 24'h0);
    tests++; if (all_done !== 1'b1) begin fails++; $display("[TB] FAIL clean_all_done: got %b want 1", all_done); end
    tests++; if (done_pulses - base != 2) begin fails++; $display("[TB] FAIL clean_pulses: got %0d want 2", done_pulses - base); end
    tests++; if (checksum !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL clean_f2_chk: got %h want ffffffff", checksum); end
    tests++; if (err_sticky !== 1'b0) begin fails++; $display("[TB] FAIL clean_sticky: got %b want 0", err_sticky); end
  endtask

  task automatic test_line_error();
    do_reset();
    vsync_pulse();
    send_line(8, 24'h1); drive(1'b1, 1'b0, 24'h0);
    send_line(7, 24'h1); drive(1'b1, 1'b0, 24'h0);
    send_line(8, 24'h1); drive(1'b1, 1'b0, 24'h0);
    send_line(8, 24'h1);
    tests++; if (frame_done !== 1'b1) begin fails++; $display("[TB] FAIL lerr_done: got %b want 1", frame_done); end
    tests++; if (err_flags !== 3'b001) begin fails++; $display("[TB] FAIL lerr_flags: got %b want 001", err_flags); end
    tests++; if (err_sticky !== 1'b1) begin fails++; $display("[TB] FAIL lerr_sticky: got %b want 1", err_sticky); end
    tests++; if (checksum !== 32'h7FFFFFFF) begin fails++; $display("[TB] FAIL lerr_chk: got %h want 7fffffff", checksum); end
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("[TB] FAIL lerr_cnt: got %0d want 1", frame_cnt); end
    drive(1'b1, 1'b0, 24'h0);
  endtask

  task automatic test_short_frame();
    do_reset();
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin send_line(8, 24'h1); drive(1'b1, 1'b0, 24'h0); end
    drive(1'b0, 1'b0, 24'h0);
    tests++; if (frame_done !== 1'b1) begin fails++; $display("[TB] FAIL short_done: got %b want 1", frame_done); end
    tests++; if (err_flags !== 3'b010) begin fails++; $display("[TB] FAIL short_flags: got %b want 010", err_flags); end
    tests++; if (checksum !== 32'h00FFFFFF) begin fails++; $display("[TB] FAIL short_chk: got %h want 00ffffff", checksum); end
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("[TB] FAIL short_cnt: got %0d want 1", frame_cnt); end
    drive(1'b0, 1'b0, 24'h0);
    tests++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL short_pulse_width: got %b want 0", frame_done); end
    drive(1'b1, 1'b0, 24'h0);
    for (int l = 0; l < 3; l++) begin send_line(8, 24'h1); drive(1'b1, 1'b0, 24'h0); end
    send_line(8, 24'h1);
    tests++; if (frame_done !== 1'b1) begin fails++; $display("[TB] FAIL short_next_done: got %b want 1", frame_done); end
    tests++; if (err_flags !== 3'b000) begin fails++; $display("[TB] FAIL short_next_flags: got %b want 000", err_flags); end
    tests++; if (frame_cnt !== 16'd2) begin fails++; $display("[TB] FAIL short_next_cnt: got %0d want 2", frame_cnt); end
    tests++; if (err_sticky !== 1'b1) begin fails++; $display("[TB] FAIL short_sticky: got %b want 1", err_sticky); end
    drive(1'b1, 1'b0, 24'h0);
    tests++; if (all_done !== 1'b1) begin fails++; $display("[TB] FAIL short_all_done: got %b want 1", all_done); end
  endtask

  task automatic test_extra_data();
    do_reset();
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin send_line(8, 24'h1); drive(1'b1, 1'b0, 24'h0); end
    send_line(8, 24'h1);
    drive(1'b1, 1'b0, 24'h0);
    drive(1'b1, 1'b0, 24'h0);
    tests++; if (err_flags !== 3'b000) begin fails++; $display("[TB] FAIL extra_pre_flags: got %b want 000", err_flags); end
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 24'h1);
    drive(1'b1, 1'b0, 24'h0);
    tests++; if (err_flags !== 3'b100) begin fails++; $display("[TB] FAIL extra_flags: got %b want 100", err_flags); end
    tests++; if (err_sticky !== 1'b1) begin fails++; $display("[TB] FAIL extra_sticky: got %b want 1", err_sticky); end
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("[TB] FAIL extra_cnt: got %0d want 1", frame_cnt); end
    tests++; if (checksum !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL extra_chk: got %h want ffffffff", checksum); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    vsync_pulse();
    send_line(7, 24'h1); drive(1'b1, 1'b0, 24'h0);
    for (int l = 0; l < 2; l++) begin send_line(8, 24'h1); drive(1'b1, 1'b0, 24'h0); end
    send_line(8, 24'h1);
    drive(1'b1, 1'b0, 24'h0);
    vsync_pulse();
    send_line(8, 24'h1); drive(1'b1, 1'b0, 24'h0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 24'h1);
    rst_n = 1'b0;
    #2;
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("[TB] FAIL mid_rst_cnt: got %0d want 0", frame_cnt); end
    tests++; if (err_sticky !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_sticky: got %b want 0", err_sticky); end
    tests++; if (err_flags !== 3'b000) begin fails++; $display("[TB] FAIL mid_rst_flags: got %b want 000", err_flags); end
    tests++; if (checksum !== 32'd0) begin fails++; $display("[TB] FAIL mid_rst_chk: got %h want 0", checksum); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 24'h5);
    drive(1'b1, 1'b0, 24'h0);
    for (int l = 0; l < 4; l++) begin send_line(8, 24'h7); drive(1'b1, 1'b0, 24'h0); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("[TB] FAIL mid_ignore_cnt: got %0d want 0", frame_cnt); end
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin send_line(8, 24'h1); drive(1'b1, 1'b0, 24'h0); end
    send_line(8, 24'h1);
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("[TB] FAIL mid_after_cnt: got %0d want 1", frame_cnt); end
    tests++; if (err_flags !== 3'b000) begin fails++; $display("[TB] FAIL mid_after_flags: got %b want 000", err_flags); end
    tests++; if (checksum !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL mid_after_chk: got %h want ffffffff", checksum); end
    drive(1'b1, 1'b0, 24'h0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    base = done_pulses;
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin send_line(8, 24'h1); drive(1'b1, 1'b0, 24'h0); end
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 24'h1);
    drive(1'b0, 1'b0, 24'h0);
    tests++; if (frame_done !== 1'b1) begin fails++; $display("[TB] FAIL b2b_done: got %b want 1", frame_done); end
    tests++; if (err_flags !== 3'b000) begin fails++; $display("[TB] FAIL b2b_flags: got %b want 000", err_flags); end
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("[TB] FAIL b2b_cnt: got %0d want 1", frame_cnt); end
    tests++; if (checksum !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL b2b_chk: got %h want ffffffff", checksum); end
    drive(1'b0, 1'b0, 24'h0);
    drive(1'b1, 1'b0, 24'h0);
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("[TB] FAIL b2b_once: got %0d want 1", frame_cnt); end
    tests++; if (done_pulses - base != 1) begin fails++; $display("[TB] FAIL b2b_pulses1: got %0d want 1", done_pulses - base); end
    for (int l = 0; l < 3; l++) begin send_line(8, 24'h3); drive(1'b1, 1'b0, 24'h0); end
    send_line(8, 24'h3);
    tests++; if (frame_done !== 1'b1) begin fails++; $display("[TB] FAIL b2b_f2_done: got %b want 1", frame_done); end
    tests++; if (frame_cnt !== 16'd2) begin fails++; $display("[TB] FAIL b2b_f2_cnt: got %0d want 2", frame_cnt); end
    tests++; if (checksum !== 32'h00000000) begin fails++; $display("[TB] FAIL b2b_f2_chk: got %h want 00000000", checksum); end
    tests++; if (err_flags !== 3'b000) begin fails++; $display("[TB] FAIL b2b_f2_flags: got %b want 000", err_flags); end
    drive(1'b1, 1'b0, 24'h0);
    tests++; if (all_done !== 1'b1) begin fails++; $display("[TB] FAIL b2b_all_done: got %b want 1", all_done); end
    tests++; if (done_pulses - base != 2) begin fails++; $display("[TB] FAIL b2b_pulses2: got %0d want 2", done_pulses - base); end
  endtask

  initial begin
    test_reset();
    test_clean_frames();
    test_line_error();
    test_short_frame();
    test_extra_data();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
